// File: rtl/intersection_pkg.sv
// Shared lamp encodings, phase codes and the phase-to-lamp mapping for the
// intersection controller and any sibling lamp blocks.
package intersection_pkg;

  localparam logic [0:2] LAMP_RED    = 3'b100;
  localparam logic [0:2] LAMP_GREEN  = 3'b010;
  localparam logic [0:2] LAMP_YELLOW = 3'b001;

  // Code 7 is deliberately unused; the controller treats it as illegal.
  typedef enum logic [2:0] {
    PH_MAIN_GREEN  = 3'd0,
    PH_MAIN_YELLOW = 3'd1,
    PH_ALL_RED_1   = 3'd2,
    PH_SIDE_GREEN  = 3'd3,
    PH_SIDE_YELLOW = 3'd4,
    PH_ALL_RED_2   = 3'd5,
    PH_PED_WALK    = 3'd6
  } phase_e;

  typedef struct packed {
    logic [0:2] main_l;
    logic [0:2] side_l;
    logic       walk_l;
  } lamps_t;

  function automatic lamps_t lamps_of(input logic [2:0] ph);
    lamps_t l;
    l.main_l = LAMP_RED;
    l.side_l = LAMP_RED;
    l.walk_l = 1'b0;
    case (ph)
      PH_MAIN_GREEN:  l.main_l = LAMP_GREEN;
      PH_MAIN_YELLOW: l.main_l = LAMP_YELLOW;
      PH_SIDE_GREEN:  l.side_l = LAMP_GREEN;
      PH_SIDE_YELLOW: l.side_l = LAMP_YELLOW;
      PH_PED_WALK:    l.walk_l = 1'b1;
      default:        ;
    endcase
    return l;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/intersection_scheduler_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// shared by the lamp blocks that time their phases in ticks.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic fast_clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-way intersection controller: main/side lamp groups plus pedestrian walk,
// phases timed in prescaler ticks and served from latched requests.
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int MAIN_MIN   = 10,
  parameter int SIDE_GREEN = 6,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 1,
  parameter int WALK       = 5
) (
  input  logic       fast_clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [0:2] main_light,
  output logic [0:2] side_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic       tick
);

  localparam logic [2:0] S_MAIN_GREEN  = PH_MAIN_GREEN;
  localparam logic [2:0] S_MAIN_YELLOW = PH_MAIN_YELLOW;
  localparam logic [2:0] S_ALL_RED_1   = PH_ALL_RED_1;
  localparam logic [2:0] S_SIDE_GREEN  = PH_SIDE_GREEN;
  localparam logic [2:0] S_SIDE_YELLOW = PH_SIDE_YELLOW;
  localparam logic [2:0] S_ALL_RED_2   = PH_ALL_RED_2;
  localparam logic [2:0] S_PED_WALK    = PH_PED_WALK;
  localparam logic [2:0] S_ILLEGAL     = 3'd7;

  localparam int MAXD = max_int(max_int(max_int(MAIN_MIN, SIDE_GREEN),
                                        max_int(YELLOW, ALL_RED)), WALK);
  localparam int TW = (MAXD > 1) ? $clog2(MAXD) : 1;

  localparam logic [TW-1:0] T_MAIN    = TW'(MAIN_MIN - 1);
  localparam logic [TW-1:0] T_SIDE    = TW'(SIDE_GREEN - 1);
  localparam logic [TW-1:0] T_YELLOW  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] T_ALL_RED = TW'(ALL_RED - 1);
  localparam logic [TW-1:0] T_WALK    = TW'(WALK - 1);

  logic          w_tick;
  logic [2:0]    r_phase;
  logic [TW-1:0] r_timer;
  logic          r_side_pend;
  logic          r_ped_pend;
  logic [0:2]    r_main_light;
  logic [0:2]    r_side_light;
  logic          r_walk;

  logic [2:0]    w_next_phase;
  logic [TW-1:0] w_next_timer;
  logic          w_enter_side;
  logic          w_enter_ped;
  lamps_t        w_lamps;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .fast_clk (fast_clk),
    .reset    (reset),
    .tick     (w_tick)
  );

  // Main green parks with timer at 0 until a request is latched.
  always_comb begin
    w_next_phase = r_phase;
    w_next_timer = r_timer;
    if (r_phase == S_ILLEGAL) begin
      w_next_phase = S_ALL_RED_2;
      w_next_timer = T_ALL_RED;
    end else if (w_tick) begin
      if (r_timer != '0) begin
        w_next_timer = r_timer - TW'(1);
      end else begin
        case (r_phase)
          S_MAIN_GREEN: begin
            if (r_side_pend || r_ped_pend) begin
              w_next_phase = S_MAIN_YELLOW;
              w_next_timer = T_YELLOW;
            end
          end
          S_MAIN_YELLOW: begin
            w_next_phase = S_ALL_RED_1;
            w_next_timer = T_ALL_RED;
          end
          S_ALL_RED_1: begin
            w_next_phase = r_side_pend ? S_SIDE_GREEN : S_PED_WALK;
            w_next_timer = r_side_pend ? T_SIDE : T_WALK;
          end
          S_SIDE_GREEN: begin
            w_next_phase = S_SIDE_YELLOW;
            w_next_timer = T_YELLOW;
          end
          S_SIDE_YELLOW: begin
            w_next_phase = S_ALL_RED_2;
            w_next_timer = T_ALL_RED;
          end
          S_ALL_RED_2: begin
            w_next_phase = r_ped_pend ? S_PED_WALK : S_MAIN_GREEN;
            w_next_timer = r_ped_pend ? T_WALK : T_MAIN;
          end
          S_PED_WALK: begin
            w_next_phase = S_ALL_RED_2;
            w_next_timer = T_ALL_RED;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_enter_side = (w_next_phase == S_SIDE_GREEN) && (r_phase != S_SIDE_GREEN);
  assign w_enter_ped  = (w_next_phase == S_PED_WALK) && (r_phase != S_PED_WALK);
  assign w_lamps      = lamps_of(w_next_phase);

  // Lamps are registered from the next phase so they track phase with no lag.
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      r_phase      <= S_ALL_RED_2;
      r_timer      <= T_ALL_RED;
      r_side_pend  <= 1'b0;
      r_ped_pend   <= 1'b0;
      r_main_light <= LAMP_RED;
      r_side_light <= LAMP_RED;
      r_walk       <= 1'b0;
    end else begin
      r_phase      <= w_next_phase;
      r_timer      <= w_next_timer;
      r_main_light <= w_lamps.main_l;
      r_side_light <= w_lamps.side_l;
      r_walk       <= w_lamps.walk_l;
      if (w_enter_side) begin
        r_side_pend <= 1'b0;
      end else if (side_req && (r_phase != S_SIDE_GREEN)) begin
        r_side_pend <= 1'b1;
      end
      if (w_enter_ped) begin
        r_ped_pend <= 1'b0;
      end else if (ped_req && (r_phase != S_PED_WALK)) begin
        r_ped_pend <= 1'b1;
      end
    end
  end

  assign main_light = r_main_light;
  assign side_light = r_side_light;
  assign walk       = r_walk;
  assign phase      = r_phase;
  assign tick       = w_tick;

endmodule
